alu_share_arbiter: RTL

//   Shares one combinational 4-bit myALU (A,B,S -> C,Co) between two requesters.

---
 rtl/alu_share_arbiter_if.sv | 45 ++++
 rtl/alu_share_arbiter.sv | 117 +++++++++++
 2 files changed

// File: rtl/alu_share_arbiter_if.sv
// Bundle between two datapath requesters, the shared arbiter and the myALU.
// slave: arbiter side. master: clients + myALU side.
interface alu_share_arbiter_if #(
    parameter int WIDTH = 4,
    parameter int OP_W  = 2
) ();
    logic             req0;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic [OP_W-1:0]  op0;
    logic             req1;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic [OP_W-1:0]  op1;
    logic             gnt0;
    logic             gnt1;
    logic             done0;
    logic             done1;
    logic [WIDTH-1:0] res;
    logic             co;
    logic             busy;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [OP_W-1:0]  alu_s;
    logic [WIDTH-1:0] alu_c;
    logic             alu_co;

    modport slave (
        input  req0, a0, b0, op0,
        input  req1, a1, b1, op1,
        input  alu_c, alu_co,
        output gnt0, gnt1, done0, done1,
        output res, co, busy,
        output alu_a, alu_b, alu_s
    );

    modport master (
        output req0, a0, b0, op0,
        output req1, a1, b1, op1,
        output alu_c, alu_co,
        input  gnt0, gnt1, done0, done1,
        input  res, co, busy,
        input  alu_a, alu_b, alu_s
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational myALU between two requesters.
// Ports: clk, rst_n (async active-low), bus (slave side of alu_share_arbiter_if).
module alu_share_arbiter #(
    parameter int WIDTH = 4,
    parameter int OP_W  = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_share_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;

    logic             ptr;
    logic             owner;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [OP_W-1:0]  ops;
    logic [WIDTH-1:0] res_q;
    logic             co_q;

    logic             win;
    logic             take;
    logic             cap;
    logic             adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Winner: a lone requester always wins; on contention ptr decides.
    always_comb begin
        state_nx = state;
        win      = owner;
        take     = 1'b0;
        cap      = 1'b0;
        adv      = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    take     = 1'b1;
                    win      = (bus.req0 && bus.req1) ? ptr : bus.req1;
                    state_nx = EXEC;
                end
            end
            EXEC: begin
                cap      = 1'b1;
                state_nx = DONE;
            end
            DONE: begin
                adv      = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Operand regs feed the ALU directly so its inputs never glitch
    // with requester activity while an op is in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner <= 1'b0;
            opa   <= '0;
            opb   <= '0;
            ops   <= '0;
        end else if (take) begin
            owner <= win;
            opa   <= win ? bus.a1  : bus.a0;
            opb   <= win ? bus.b1  : bus.b0;
            ops   <= win ? bus.op1 : bus.op0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q <= '0;
            co_q  <= 1'b0;
        end else if (cap) begin
            res_q <= bus.alu_c;
            co_q  <= bus.alu_co;
        end
    end

    // Priority flips to the other requester once an op retires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= 1'b0;
        end else if (adv) begin
            ptr <= ~owner;
        end
    end

    assign bus.busy  = (state != IDLE);
    assign bus.gnt0  = bus.busy & ~owner;
    assign bus.gnt1  = bus.busy & owner;
    assign bus.done0 = (state == DONE) & ~owner;
    assign bus.done1 = (state == DONE) & owner;
    assign bus.res   = res_q;
    assign bus.co    = co_q;
    assign bus.alu_a = opa;
    assign bus.alu_b = opb;
    assign bus.alu_s = ops;

endmodule
